// File: rtl/bsg_fsb_node_pwr_pkg.sv
// Shared types for the FSB node power sequencer: state encoding and per-state output decode.
package bsg_fsb_node_pwr_pkg;

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_PWR_UP = 3'd1,
    S_LS_EN  = 3'd2,
    S_ON     = 3'd3,
    S_DRAIN  = 3'd4,
    S_LS_DIS = 3'd5,
    S_PWR_DN = 3'd6
  } state_e;

  // Output vector ordering: {pwr_en, en_ls, node_reset, quiesce}
  localparam logic [3:0] OUT_OFF    = 4'b0011;
  localparam logic [3:0] OUT_PWR_UP = 4'b1011;
  localparam logic [3:0] OUT_LS_EN  = 4'b1111;
  localparam logic [3:0] OUT_ON     = 4'b1100;
  localparam logic [3:0] OUT_DRAIN  = 4'b1101;
  localparam logic [3:0] OUT_LS_DIS = 4'b1011;
  localparam logic [3:0] OUT_PWR_DN = 4'b0011;

  function automatic logic [3:0] state_outputs(input state_e s);
    logic [3:0] o;
    o = OUT_OFF;
    case (s)
      S_OFF:    o = OUT_OFF;
      S_PWR_UP: o = OUT_PWR_UP;
      S_LS_EN:  o = OUT_LS_EN;
      S_ON:     o = OUT_ON;
      S_DRAIN:  o = OUT_DRAIN;
      S_LS_DIS: o = OUT_LS_DIS;
      S_PWR_DN: o = OUT_PWR_DN;
      default:  o = OUT_OFF;
    endcase
    return o;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Saturating up-counter with synchronous clear; clear has priority over count.
module bsg_counter_clear_up #(
  parameter int width_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] r_count;
  logic               w_sat;

  assign w_sat = &r_count;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      r_count <= '0;
    else if (clear_i)
      r_count <= '0;
    else if (up_i && !w_sat)
      r_count <= r_count + 1'b1;
  end

  assign count_o = r_count;

endmodule

// File: rtl/bsg_fsb_node_ls_power_seq.sv
// Power/isolation sequencer driving the FSB node level shifter's en_ls_i and reset_i.
// Optional power-good timeout enabled by defining BSG_FSB_NODE_PWR_TIMEOUT_EN.
module bsg_fsb_node_ls_power_seq
  import bsg_fsb_node_pwr_pkg::*;
#(
  parameter int reset_cycles_p       = 16,
  parameter int drain_quiet_cycles_p = 4,
  parameter int iso_cycles_p         = 2,
  parameter int pwr_timeout_p        = 1024
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       node_en_i,
  input  logic       node_pwr_good_i,
  input  logic       fsb_v_i,
  input  logic       node_v_i,
  output logic       node_pwr_en_o,
  output logic       en_ls_o,
  output logic       node_reset_o,
  output logic       quiesce_o,
  output logic       node_on_o,
  output logic       pwr_err_o,
  output logic [2:0] state_o
);

`ifdef BSG_FSB_NODE_PWR_TIMEOUT_EN
  localparam int MAX_P = max2(max2(reset_cycles_p, drain_quiet_cycles_p),
                              max2(iso_cycles_p, pwr_timeout_p));
`else
  localparam int MAX_P = max2(max2(reset_cycles_p, drain_quiet_cycles_p), iso_cycles_p);
`endif
  localparam int CW = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] RST_LAST   = CW'(reset_cycles_p - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(drain_quiet_cycles_p - 1);
  localparam logic [CW-1:0] ISO_LAST   = CW'(iso_cycles_p - 1);
`ifdef BSG_FSB_NODE_PWR_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST    = CW'(pwr_timeout_p - 1);
`endif

  state_e          r_state;
  state_e          w_next;
  logic [CW-1:0]   w_cnt;
  logic            w_cnt_clr;
  logic            w_quiet;
  logic            w_err_set;
  logic [3:0]      w_out;

  assign w_quiet = !fsb_v_i && !node_v_i;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      r_state <= S_OFF;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_err_set = 1'b0;
    case (r_state)
      S_OFF:
        if (node_en_i) w_next = S_PWR_UP;
      S_PWR_UP:
        if (!node_en_i)
          w_next = S_PWR_DN;
        else if (node_pwr_good_i)
          w_next = S_LS_EN;
`ifdef BSG_FSB_NODE_PWR_TIMEOUT_EN
        else if (w_cnt == TO_LAST) begin
          w_next    = S_PWR_DN;
          w_err_set = 1'b1;
        end
`endif
      S_LS_EN:
        if (!node_en_i)
          w_next = S_LS_DIS;
        else if (w_cnt == RST_LAST)
          w_next = S_ON;
      S_ON:
        if (!node_en_i) w_next = S_DRAIN;
      S_DRAIN:
        if (node_en_i)
          w_next = S_ON;
        else if (w_quiet && (w_cnt == DRAIN_LAST))
          w_next = S_LS_DIS;
      S_LS_DIS:
        if (w_cnt == ISO_LAST) w_next = S_PWR_DN;
      S_PWR_DN:
        if (!node_pwr_good_i) w_next = S_OFF;
      default:
        w_next = S_OFF;
    endcase
  end

  // In DRAIN the counter measures consecutive quiet cycles, so any traffic restarts it.
  assign w_cnt_clr = (w_next != r_state) || ((r_state == S_DRAIN) && !w_quiet);

  bsg_counter_clear_up #(
    .width_p (CW)
  ) u_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (w_cnt_clr),
    .up_i    (1'b1),
    .count_o (w_cnt)
  );

`ifdef BSG_FSB_NODE_PWR_TIMEOUT_EN
  logic r_pwr_err;
  always_ff @(posedge clk_i) begin
    if (reset_i)
      r_pwr_err <= 1'b0;
    else if ((w_next == S_ON) && (r_state != S_ON))
      r_pwr_err <= 1'b0;
    else if (w_err_set)
      r_pwr_err <= 1'b1;
  end
  assign pwr_err_o = r_pwr_err;
`else
  assign pwr_err_o = 1'b0;
`endif

  assign w_out         = state_outputs(r_state);
  assign node_pwr_en_o = w_out[3];
  assign en_ls_o       = w_out[2];
  assign node_reset_o  = w_out[1];
  assign quiesce_o     = w_out[0];
  assign node_on_o     = (r_state == S_ON);
  assign state_o       = r_state;

  a_ls_needs_pwr: assert property (@(posedge clk_i) en_ls_o |-> node_pwr_en_o);
  a_ls_rise_in_reset: assert property (@(posedge clk_i) disable iff (reset_i)
                                       $rose(en_ls_o) |-> node_reset_o);
  a_ls_fall_in_reset: assert property (@(posedge clk_i) disable iff (reset_i)
                                       $fell(en_ls_o) |-> node_reset_o);
  a_on_decode: assert property (@(posedge clk_i) node_on_o == (r_state == S_ON));

endmodule

// File: tb/tb_bsg_fsb_node_ls_power_seq.sv
// Directed bench for bsg_fsb_node_ls_power_seq; timeout scenario runs when BSG_FSB_NODE_PWR_TIMEOUT_EN is defined.
module tb_bsg_fsb_node_ls_power_seq;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       node_en_i;
  logic       node_pwr_good_i;
  logic       fsb_v_i;
  logic       node_v_i;
  logic       node_pwr_en_o;
  logic       en_ls_o;
  logic       node_reset_o;
  logic       quiesce_o;
  logic       node_on_o;
  logic       pwr_err_o;
  logic [2:0] state_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  bsg_fsb_node_ls_power_seq #(
    .reset_cycles_p       (16),
    .drain_quiet_cycles_p (4),
    .iso_cycles_p         (2),
    .pwr_timeout_p        (8)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .node_en_i       (node_en_i),
    .node_pwr_good_i (node_pwr_good_i),
    .fsb_v_i         (fsb_v_i),
    .node_v_i        (node_v_i),
    .node_pwr_en_o   (node_pwr_en_o),
    .en_ls_o         (en_ls_o),
    .node_reset_o    (node_reset_o),
    .quiesce_o       (quiesce_o),
    .node_on_o       (node_on_o),
    .pwr_err_o       (pwr_err_o),
    .state_o         (state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic power_up_to_on();
    node_en_i = 1'b1;
    node_pwr_good_i = 1'b1;
    step(18);
    chk("pu_state_on", 32'(state_o), 32'd3);
  endtask

  initial begin
    reset_i = 1'b1;
    node_en_i = 1'b0;
    node_pwr_good_i = 1'b0;
    fsb_v_i = 1'b0;
    node_v_i = 1'b0;
    step(2);
    chk("rst_state",   32'(state_o), 32'd0);
    chk("rst_pwr_en",  32'(node_pwr_en_o), 32'd0);
    chk("rst_en_ls",   32'(en_ls_o), 32'd0);
    chk("rst_nreset",  32'(node_reset_o), 32'd1);
    chk("rst_quiesce", 32'(quiesce_o), 32'd1);
    chk("rst_on",      32'(node_on_o), 32'd0);
    chk("rst_err",     32'(pwr_err_o), 32'd0);
    reset_i = 1'b0;
    step(1);

    // Power-up
    node_en_i = 1'b1;
    step(1);
    chk("t1_pwr_en_t1", 32'(node_pwr_en_o), 32'd1);
    chk("t1_en_ls_t1",  32'(en_ls_o), 32'd0);
    chk("t1_state_t1",  32'(state_o), 32'd1);
    step(4);
    node_pwr_good_i = 1'b1;
    chk("t1_en_ls_t5",  32'(en_ls_o), 32'd0);
    step(1);
    chk("t1_en_ls_t6",  32'(en_ls_o), 32'd1);
    chk("t1_nrst_t6",   32'(node_reset_o), 32'd1);
    chk("t1_state_t6",  32'(state_o), 32'd2);
    step(15);
    chk("t1_nrst_t21",  32'(node_reset_o), 32'd1);
    chk("t1_on_t21",    32'(node_on_o), 32'd0);
    step(1);
    chk("t1_nrst_t22",  32'(node_reset_o), 32'd0);
    chk("t1_on_t22",    32'(node_on_o), 32'd1);
    chk("t1_quies_t22", 32'(quiesce_o), 32'd0);

    // Drain with traffic at cycles 2 and 5
    node_en_i = 1'b0;
    step(1);
    chk("t2_quiesce_c1", 32'(quiesce_o), 32'd1);
    chk("t2_state_c1",   32'(state_o), 32'd4);
    step(1);
    fsb_v_i = 1'b1;
    step(1);
    fsb_v_i = 1'b0;
    step(2);
    fsb_v_i = 1'b1;
    step(1);
    fsb_v_i = 1'b0;
    step(3);
    chk("t2_en_ls_c9",   32'(en_ls_o), 32'd1);
    chk("t2_state_c9",   32'(state_o), 32'd4);
    step(1);
    chk("t2_en_ls_c10",  32'(en_ls_o), 32'd0);
    chk("t2_state_c10",  32'(state_o), 32'd5);
    chk("t2_pwr_c10",    32'(node_pwr_en_o), 32'd1);
    step(1);
    chk("t2_pwr_c11",    32'(node_pwr_en_o), 32'd1);
    step(1);
    chk("t2_pwr_c12",    32'(node_pwr_en_o), 32'd0);
    chk("t2_state_c12",  32'(state_o), 32'd6);
    step(1);
    chk("t2_pwrdn_hold", 32'(state_o), 32'd6);
    node_pwr_good_i = 1'b0;
    step(1);
    chk("t2_off",        32'(state_o), 32'd0);

    // Abort during LS_EN at count 7
    node_en_i = 1'b1;
    node_pwr_good_i = 1'b1;
    step(2);
    chk("t3_state_lsen", 32'(state_o), 32'd2);
    for (int i = 0; i < 7; i++) begin
      step(1);
      chk("t3_nrst_lsen", 32'(node_reset_o), 32'd1);
      chk("t3_on_lsen",   32'(node_on_o), 32'd0);
    end
    node_en_i = 1'b0;
    step(1);
    chk("t3_state_lsdis", 32'(state_o), 32'd5);
    chk("t3_nrst_lsdis",  32'(node_reset_o), 32'd1);
    chk("t3_on_lsdis",    32'(node_on_o), 32'd0);
    step(2);
    chk("t3_state_pwrdn", 32'(state_o), 32'd6);
    node_pwr_good_i = 1'b0;
    step(1);
    chk("t3_off",         32'(state_o), 32'd0);

    // Re-request in DRAIN
    power_up_to_on();
    node_en_i = 1'b0;
    step(1);
    chk("t4_state_drain", 32'(state_o), 32'd4);
    chk("t4_en_ls_c1",    32'(en_ls_o), 32'd1);
    step(1);
    node_en_i = 1'b1;
    chk("t4_en_ls_c2",    32'(en_ls_o), 32'd1);
    step(1);
    chk("t4_state_on",    32'(state_o), 32'd3);
    chk("t4_quiesce",     32'(quiesce_o), 32'd0);
    chk("t4_en_ls_c3",    32'(en_ls_o), 32'd1);

    // Reset while ON
    reset_i = 1'b1;
    step(1);
    chk("t6_state",   32'(state_o), 32'd0);
    chk("t6_en_ls",   32'(en_ls_o), 32'd0);
    chk("t6_pwr_en",  32'(node_pwr_en_o), 32'd0);
    chk("t6_nreset",  32'(node_reset_o), 32'd1);
    reset_i = 1'b0;
    node_en_i = 1'b0;
    node_pwr_good_i = 1'b0;
    step(1);

`ifdef BSG_FSB_NODE_PWR_TIMEOUT_EN
    // Power-good timeout, pwr_timeout_p = 8
    node_en_i = 1'b1;
    step(1);
    chk("t5_state_c1",  32'(state_o), 32'd1);
    step(7);
    chk("t5_state_c8",  32'(state_o), 32'd1);
    chk("t5_err_c8",    32'(pwr_err_o), 32'd0);
    step(1);
    chk("t5_state_c9",  32'(state_o), 32'd6);
    chk("t5_err_c9",    32'(pwr_err_o), 32'd1);
    node_en_i = 1'b0;
    step(1);
    chk("t5_state_off", 32'(state_o), 32'd0);
    chk("t5_err_off",   32'(pwr_err_o), 32'd1);
    step(1);
    chk("t5_err_off2",  32'(pwr_err_o), 32'd1);
    power_up_to_on();
    chk("t5_err_on",    32'(pwr_err_o), 32'd0);
`else
    // Without the timeout the sequencer waits in PWR_UP indefinitely
    node_en_i = 1'b1;
    step(20);
    chk("t5_wait_state", 32'(state_o), 32'd1);
    chk("t5_wait_err",   32'(pwr_err_o), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
